// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch (i_*), load/store (d_*) and unified memory (m_*) channels
// of the memory port arbiter. "slave" is the arbiter's view, "master" the environment's.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Fetch requester
  logic            i_valid;
  logic [AW-1:0]   i_addr;
  logic            i_ready;
  logic            i_rvalid;
  logic [DW-1:0]   i_rdata;
  // Load/store requester
  logic            d_valid;
  logic            d_we;
  logic [DW/8-1:0] d_be;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic            d_ready;
  logic            d_rvalid;
  logic [DW-1:0]   d_rdata;
  // Memory side
  logic            m_valid;
  logic            m_we;
  logic [DW/8-1:0] m_be;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic            m_ready;
  logic            m_rvalid;
  logic [DW-1:0]   m_rdata;

  modport slave (
    input  i_valid, i_addr,
    input  d_valid, d_we, d_be, d_addr, d_wdata,
    input  m_ready, m_rvalid, m_rdata,
    output i_ready, i_rvalid, i_rdata,
    output d_ready, d_rvalid, d_rdata,
    output m_valid, m_we, m_be, m_addr, m_wdata
  );

  modport master (
    output i_valid, i_addr,
    output d_valid, d_we, d_be, d_addr, d_wdata,
    output m_ready, m_rvalid, m_rdata,
    input  i_ready, i_rvalid, i_rdata,
    input  d_ready, d_rvalid, d_rdata,
    input  m_valid, m_we, m_be, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D).
// One outstanding transaction; D has priority unless I has been starved STARVE_LIMIT times.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);
  localparam int BW = DW / 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  typedef enum logic       {OWN_I, OWN_D}         owner_t;

  state_t          r_state;
  state_t          w_next_state;
  owner_t          r_owner;
  logic [3:0]      r_starve_cnt;
  logic            r_m_we;
  logic [BW-1:0]   r_m_be;
  logic [AW-1:0]   r_m_addr;
  logic [DW-1:0]   r_m_wdata;

  logic w_idle;
  logic w_force_i;
  logic w_grant_d;
  logic w_grant_i;

  // Grants are suppressed while rst is high so nothing is captured during reset.
  assign w_idle    = (r_state == S_IDLE) && !rst;
  assign w_force_i = bus.i_valid && (r_starve_cnt == 4'(STARVE_LIMIT));
  assign w_grant_d = w_idle && bus.d_valid && !w_force_i;
  assign w_grant_i = w_idle && bus.i_valid && !w_grant_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: default assignment first so no path leaves w_next_state unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (w_grant_d || w_grant_i) w_next_state = S_REQ;
      S_REQ:  if (bus.m_ready)            w_next_state = S_WAIT;
      S_WAIT: if (bus.m_rvalid)           w_next_state = S_IDLE;
      default:                            w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.i_ready  = w_grant_i;
    bus.d_ready  = w_grant_d;
    bus.m_valid  = (r_state == S_REQ) && !rst;
    bus.i_rvalid = 1'b0;
    bus.d_rvalid = 1'b0;
    if ((r_state == S_WAIT) && bus.m_rvalid && !rst) begin
      bus.i_rvalid = (r_owner == OWN_I);
      bus.d_rvalid = (r_owner == OWN_D);
    end
    bus.i_rdata  = bus.m_rdata;
    bus.d_rdata  = bus.m_rdata;
    bus.m_we     = r_m_we;
    bus.m_be     = r_m_be;
    bus.m_addr   = r_m_addr;
    bus.m_wdata  = r_m_wdata;
  end

  // Request capture and starvation tracking; the counter only moves on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= OWN_I;
      r_starve_cnt <= '0;
      r_m_we       <= 1'b0;
      r_m_be       <= '0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
    end else if (w_grant_d) begin
      r_owner   <= OWN_D;
      r_m_we    <= bus.d_we;
      r_m_be    <= bus.d_be;
      r_m_addr  <= bus.d_addr;
      r_m_wdata <= bus.d_wdata;
      if (!bus.i_valid)
        r_starve_cnt <= '0;
      else if (r_starve_cnt != 4'(STARVE_LIMIT))
        r_starve_cnt <= r_starve_cnt + 4'd1;
    end else if (w_grant_i) begin
      r_owner      <= OWN_I;
      r_m_we       <= 1'b0;
      r_m_be       <= '1;
      r_m_addr     <= bus.i_addr;
      r_m_wdata    <= '0;
      r_starve_cnt <= '0;
    end
  end
endmodule
